// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register console: FSM states,
// OV7670 device address and timeout counter sizing.
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_CMD,
    W_ADDR,
    W_DATA,
    R_CMDW,
    R_ADDR,
    R_CMDR,
    R_DATA
  } state_t;

  localparam logic [6:0] OV7670_ADDR = 7'h21;

  // The counter only has to hold 0..limit-1, so clog2(limit) bits suffice.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/btn_release_detect.sv
// Single-cycle pulse on a 1-to-0 transition of a debounced button.
module btn_release_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rel_pulse
);

  logic hist_q;
  logic hist_d;

  always_comb begin
    hist_d    = btn;
    rel_pulse = hist_q & ~btn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/sccb_reg_console.sv
// Button-driven register console that issues SCCB (I2C) register
// writes and reads through an AXI-Stream style i2c master.
module sccb_reg_console
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = OV7670_ADDR,
  parameter int         COARSE_STEP = 16,
  parameter logic [7:0] ADDR_INIT   = 8'h00,
  parameter int         TIMEOUT     = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_c,
  input  logic       mode_read,
  input  logic [7:0] wr_data,
  output logic [7:0] reg_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       err,
  output logic [6:0] s_axis_cmd_address,
  output logic       s_axis_cmd_start,
  output logic       s_axis_cmd_read,
  output logic       s_axis_cmd_write,
  output logic       s_axis_cmd_write_multiple,
  output logic       s_axis_cmd_stop,
  output logic       s_axis_cmd_valid,
  input  logic       s_axis_cmd_ready,
  output logic [7:0] s_axis_data_tdata,
  output logic       s_axis_data_tvalid,
  output logic       s_axis_data_tlast,
  input  logic       s_axis_data_tready,
  input  logic [7:0] m_axis_data_tdata,
  input  logic       m_axis_data_tvalid,
  input  logic       m_axis_data_tlast,
  output logic       m_axis_data_tready
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       STEP     = 8'(COARSE_STEP);

  logic [4:0] btn_vec;
  logic [4:0] evt;
  logic       evt_l, evt_r, evt_u, evt_d, evt_c;
  logic       unused_tlast;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       lat_addr_q, lat_addr_d;
  logic [7:0]       lat_data_q, lat_data_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_read_q, cmd_read_d;
  logic             cmd_write_q, cmd_write_d;
  logic             cmd_wm_q, cmd_wm_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             m_tready_q, m_tready_d;
  logic             cmd_hs, wr_hs, rd_hs, expired;

  assign btn_vec = {btn_c, btn_d, btn_u, btn_r, btn_l};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_release_detect u_det (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn_vec[i]),
      .rel_pulse (evt[i])
    );
  end

  assign {evt_c, evt_d, evt_u, evt_r, evt_l} = evt;
  assign unused_tlast = m_axis_data_tlast;

  // Simultaneous events are summed; 8-bit arithmetic gives the wrap.
  always_comb begin
    reg_addr_d = reg_addr_q
               + {7'd0, evt_r} - {7'd0, evt_l}
               + (evt_u ? STEP : 8'd0) - (evt_d ? STEP : 8'd0);
  end

  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    err_d      = err_q;
    cmd_hs     = cmd_valid_q & s_axis_cmd_ready;
    wr_hs      = tvalid_q & s_axis_data_tready;
    rd_hs      = m_tready_q & m_axis_data_tvalid;
    expired    = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (evt_c) begin
          lat_addr_d = reg_addr_q;
          lat_data_d = wr_data;
          rd_valid_d = 1'b0;
          err_d      = 1'b0;
          state_d    = mode_read ? R_CMDW : W_CMD;
        end
      end
      W_CMD:  if (cmd_hs) state_d = W_ADDR; else if (expired) begin state_d = IDLE; err_d = 1'b1; end
      W_ADDR: if (wr_hs)  state_d = W_DATA; else if (expired) begin state_d = IDLE; err_d = 1'b1; end
      W_DATA: if (wr_hs)  state_d = IDLE;   else if (expired) begin state_d = IDLE; err_d = 1'b1; end
      R_CMDW: if (cmd_hs) state_d = R_ADDR; else if (expired) begin state_d = IDLE; err_d = 1'b1; end
      R_ADDR: if (wr_hs)  state_d = R_CMDR; else if (expired) begin state_d = IDLE; err_d = 1'b1; end
      R_CMDR: if (cmd_hs) state_d = R_DATA; else if (expired) begin state_d = IDLE; err_d = 1'b1; end
      R_DATA: begin
        if (rd_hs) begin
          rd_data_d  = m_axis_data_tdata;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    cmd_wm_d    = (state_d == W_CMD);
    cmd_write_d = (state_d == R_CMDW);
    cmd_read_d  = (state_d == R_CMDR);
    cmd_valid_d = cmd_wm_d | cmd_write_d | cmd_read_d;
    tvalid_d    = (state_d == W_ADDR) | (state_d == W_DATA) | (state_d == R_ADDR);
    tlast_d     = (state_d == W_DATA) | (state_d == R_ADDR);
    tdata_d     = (state_d == W_DATA) ? lat_data_d : lat_addr_d;
    m_tready_d  = (state_d == R_DATA);
    cnt_d       = cnt_q + 1'b1;
    if (state_d != state_q || state_q == IDLE) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reg_addr_q  <= ADDR_INIT;
      lat_addr_q  <= 8'd0;
      lat_data_q  <= 8'd0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_wm_q    <= 1'b0;
      tdata_q     <= 8'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      m_tready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_addr_q  <= reg_addr_d;
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_read_q  <= cmd_read_d;
      cmd_write_q <= cmd_write_d;
      cmd_wm_q    <= cmd_wm_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      m_tready_q  <= m_tready_d;
    end
  end

  assign reg_addr                  = reg_addr_q;
  assign rd_data                   = rd_data_q;
  assign rd_valid                  = rd_valid_q;
  assign busy                      = (state_q != IDLE);
  assign err                       = err_q;
  assign s_axis_cmd_address        = DEV_ADDR;
  assign s_axis_cmd_start          = cmd_valid_q;
  assign s_axis_cmd_stop           = cmd_valid_q;
  assign s_axis_cmd_read           = cmd_read_q;
  assign s_axis_cmd_write          = cmd_write_q;
  assign s_axis_cmd_write_multiple = cmd_wm_q;
  assign s_axis_cmd_valid          = cmd_valid_q;
  assign s_axis_data_tdata         = tdata_q;
  assign s_axis_data_tvalid        = tvalid_q;
  assign s_axis_data_tlast         = tlast_q;
  assign m_axis_data_tready        = m_tready_q;

endmodule

// File: tb/tb_sccb_reg_console.sv
// Directed self-checking bench for sccb_reg_console: navigation, write,
// read, back-pressure, timeout and reset during a transaction.
module tb_sccb_reg_console;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_l, btn_r, btn_u, btn_d, btn_c;
  logic       mode_read;
  logic [7:0] wr_data;
  logic [7:0] reg_addr, rd_data;
  logic       rd_valid, busy, err;
  logic [6:0] s_axis_cmd_address;
  logic       s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write;
  logic       s_axis_cmd_write_multiple, s_axis_cmd_stop, s_axis_cmd_valid;
  logic       s_axis_cmd_ready;
  logic [7:0] s_axis_data_tdata;
  logic       s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tready;
  logic [7:0] m_axis_data_tdata;
  logic       m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tready;

  int vectors    = 0;
  int miscompares = 0;

  sccb_reg_console #(
    .DEV_ADDR    (7'h21),
    .COARSE_STEP (16),
    .ADDR_INIT   (8'h00),
    .TIMEOUT     (50)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .btn_l                     (btn_l),
    .btn_r                     (btn_r),
    .btn_u                     (btn_u),
    .btn_d                     (btn_d),
    .btn_c                     (btn_c),
    .mode_read                 (mode_read),
    .wr_data                   (wr_data),
    .reg_addr                  (reg_addr),
    .rd_data                   (rd_data),
    .rd_valid                  (rd_valid),
    .busy                      (busy),
    .err                       (err),
    .s_axis_cmd_address        (s_axis_cmd_address),
    .s_axis_cmd_start          (s_axis_cmd_start),
    .s_axis_cmd_read           (s_axis_cmd_read),
    .s_axis_cmd_write          (s_axis_cmd_write),
    .s_axis_cmd_write_multiple (s_axis_cmd_write_multiple),
    .s_axis_cmd_stop           (s_axis_cmd_stop),
    .s_axis_cmd_valid          (s_axis_cmd_valid),
    .s_axis_cmd_ready          (s_axis_cmd_ready),
    .s_axis_data_tdata         (s_axis_data_tdata),
    .s_axis_data_tvalid        (s_axis_data_tvalid),
    .s_axis_data_tlast         (s_axis_data_tlast),
    .s_axis_data_tready        (s_axis_data_tready),
    .m_axis_data_tdata         (m_axis_data_tdata),
    .m_axis_data_tvalid        (m_axis_data_tvalid),
    .m_axis_data_tlast         (m_axis_data_tlast),
    .m_axis_data_tready        (m_axis_data_tready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press-and-release: the event lands on the second edge.
  task automatic applyStimulus(input logic [4:0] btns);
    {btn_c, btn_d, btn_u, btn_r, btn_l} = btns;
    tick();
    {btn_c, btn_d, btn_u, btn_r, btn_l} = 5'b0;
    tick();
  endtask

  task automatic goto_addr(input logic [7:0] target);
    for (int n = 0; n < 260 && reg_addr != target; n++) applyStimulus(5'b00010);
    checkOutput("goto_addr", reg_addr, target);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    {btn_c, btn_d, btn_u, btn_r, btn_l} = 5'b0;
    mode_read          = 1'b0;
    wr_data            = 8'h00;
    s_axis_cmd_ready   = 1'b1;
    s_axis_data_tready = 1'b1;
    m_axis_data_tdata  = 8'h00;
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    checkOutput("rst_reg_addr", reg_addr, 8'h00);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_cmd_valid", s_axis_cmd_valid, 0);
    checkOutput("rst_tvalid", s_axis_data_tvalid, 0);
    checkOutput("rst_m_tready", m_axis_data_tready, 0);

    applyStimulus(5'b00001);
    checkOutput("nav_l_wrap", reg_addr, 8'hFF);
    applyStimulus(5'b00010);
    checkOutput("nav_r_wrap", reg_addr, 8'h00);
    applyStimulus(5'b00100);
    checkOutput("nav_u", reg_addr, 8'h10);
    applyStimulus(5'b01000);
    checkOutput("nav_d", reg_addr, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(5'b00010);
    checkOutput("nav_r5", reg_addr, 8'h05);
    applyStimulus(5'b01000);
    checkOutput("nav_d_wrap", reg_addr, 8'hF5);
    applyStimulus(5'b00110);
    checkOutput("nav_r_plus_u", reg_addr, 8'h06);
    applyStimulus(5'b01001);
    checkOutput("nav_l_plus_d", reg_addr, 8'hF5);

    goto_addr(8'h12);
    wr_data   = 8'h80;
    mode_read = 1'b0;
    applyStimulus(5'b10000);
    checkOutput("wr_cmd_valid", s_axis_cmd_valid, 1);
    checkOutput("wr_cmd_wm", s_axis_cmd_write_multiple, 1);
    checkOutput("wr_cmd_flags", {s_axis_cmd_read, s_axis_cmd_write, s_axis_cmd_start, s_axis_cmd_stop}, 4'b0011);
    checkOutput("wr_cmd_addr", s_axis_cmd_address, 7'h21);
    checkOutput("wr_busy", busy, 1);
    tick();
    checkOutput("wr_byte0", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {2'b10, 8'h12});
    checkOutput("wr_cmd_drop", s_axis_cmd_valid, 0);
    tick();
    checkOutput("wr_byte1", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {2'b11, 8'h80});
    tick();
    checkOutput("wr_done_busy", busy, 0);
    checkOutput("wr_done_tvalid", s_axis_data_tvalid, 0);

    goto_addr(8'h0A);
    mode_read = 1'b1;
    applyStimulus(5'b10000);
    checkOutput("rd_cmdw", {s_axis_cmd_valid, s_axis_cmd_write, s_axis_cmd_read, s_axis_cmd_write_multiple}, 4'b1100);
    tick();
    checkOutput("rd_addr_byte", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {2'b11, 8'h0A});
    tick();
    checkOutput("rd_cmdr", {s_axis_cmd_valid, s_axis_cmd_write, s_axis_cmd_read, s_axis_cmd_write_multiple}, 4'b1010);
    checkOutput("rd_tvalid_off", s_axis_data_tvalid, 0);
    tick();
    checkOutput("rd_m_tready", m_axis_data_tready, 1);
    m_axis_data_tdata  = 8'h76;
    m_axis_data_tvalid = 1'b1;
    m_axis_data_tlast  = 1'b1;
    tick();
    m_axis_data_tvalid = 1'b0;
    m_axis_data_tlast  = 1'b0;
    checkOutput("rd_data", rd_data, 8'h76);
    checkOutput("rd_valid", rd_valid, 1);
    checkOutput("rd_busy", busy, 0);
    checkOutput("rd_m_tready_off", m_axis_data_tready, 0);

    goto_addr(8'h33);
    wr_data            = 8'h5A;
    mode_read          = 1'b0;
    s_axis_data_tready = 1'b0;
    applyStimulus(5'b10000);
    checkOutput("stall_rd_valid_clr", rd_valid, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 3) btn_c = 1'b1;
      if (i == 4) btn_c = 1'b0;
      if (i == 8) btn_r = 1'b1;
      if (i == 9) btn_r = 1'b0;
      checkOutput("stall_hold", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {2'b10, 8'h33});
      tick();
    end
    checkOutput("stall_nav", reg_addr, 8'h34);
    checkOutput("stall_busy", busy, 1);
    s_axis_data_tready = 1'b1;
    tick();
    checkOutput("stall_byte1", {s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tdata}, {2'b11, 8'h5A});
    tick();
    checkOutput("stall_done", busy, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stall_no_second", {busy, s_axis_cmd_valid}, 2'b00);
    end

    mode_read = 1'b1;
    applyStimulus(5'b10000);
    cnt = 0;
    for (int i = 0; i < 300 && busy; i++) begin
      if (m_axis_data_tready) cnt++;
      tick();
    end
    checkOutput("to_idle", busy, 0);
    checkOutput("to_rdata_cycles", cnt, 50);
    checkOutput("to_err", err, 1);
    checkOutput("to_rd_valid", rd_valid, 0);
    checkOutput("to_m_tready", m_axis_data_tready, 0);

    mode_read = 1'b0;
    applyStimulus(5'b10000);
    checkOutput("rst_err_clr", err, 0);
    tick();
    tick();
    s_axis_data_tready = 1'b0;
    checkOutput("pre_rst_wdata", {s_axis_data_tvalid, s_axis_data_tlast}, 2'b11);
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_valids", {s_axis_data_tvalid, s_axis_cmd_valid, m_axis_data_tready}, 3'b000);
    checkOutput("rst_mid_addr", reg_addr, 8'h00);
    checkOutput("rst_mid_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
